// File: rtl/bus_sram_slave.sv
// Word-addressed SRAM slave on the shared system bus. Decodes single and burst
// transactions inside a fixed address window, streams read data one word per
// cycle and absorbs write bursts with optional periodic back-pressure.
module bus_sram_slave #(
  parameter logic [31:0] BaseAddress = 32'h5000_0000,
  parameter int unsigned AddressBits = 10,
  parameter int unsigned BusyPeriod  = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        begin_transaction_i,
  input  logic        end_transaction_i,
  input  logic        read_not_write_i,
  input  logic        data_valid_i,
  input  logic [31:0] address_data_i,
  input  logic [3:0]  byte_enables_i,
  input  logic [7:0]  burst_size_i,
  output logic [31:0] address_data_o,
  output logic        data_valid_o,
  output logic        end_transaction_o,
  output logic        busy_o,
  output logic        bus_error_o
);

  localparam int unsigned Depth  = 2 ** AddressBits;
  localparam logic [31:0] MaxIdx = 32'(Depth - 1);

  typedef logic [AddressBits-1:0] idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StReadAddr,
    StReadBurst,
    StReadEnd,
    StWrite,
    StError
  } state_e;

  state_e      state_q;
  idx_t        idx_q;
  logic [7:0]  cnt_q;
  logic [3:0]  be_q;
  logic        rnw_q;
  logic        full_q;     // all burstSize+1 beats written; further beats are dropped
  logic        ovf_q;      // overflow error already reported for this transaction
  logic [31:0] bp_cnt_q;

  logic [31:0] rdata_q;
  logic        dvalid_q;
  logic        end_q;
  logic        busy_q;
  logic        err_q;

  logic [31:0] mem [Depth];

  logic        hit;
  idx_t        req_idx;
  logic [31:0] span_end;
  logic        range_err;
  logic        beat_acc;
  logic        mem_we;
  logic        bp_wrap;

  // Address decode, range check and write-beat acceptance.
  always_comb begin
    hit       = (address_data_i >> (AddressBits + 2)) == (BaseAddress >> (AddressBits + 2));
    req_idx   = address_data_i[AddressBits+1:2];
    span_end  = 32'(req_idx) + 32'(burst_size_i);
    range_err = span_end > MaxIdx;
    beat_acc  = (state_q == StWrite) && data_valid_i && !busy_q;
    mem_we    = beat_acc && !full_q;
    bp_wrap   = (BusyPeriod != 0) && ((bp_cnt_q + 32'd1) == BusyPeriod);
  end

  // SRAM array write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[idx_q][8*b +: 8] <= address_data_i[8*b +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered bus outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      be_q     <= '0;
      rnw_q    <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bp_cnt_q <= '0;
      rdata_q  <= '0;
      dvalid_q <= 1'b0;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // Output pulses default low; data is zero whenever not valid.
      rdata_q  <= '0;
      dvalid_q <= 1'b0;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (begin_transaction_i && hit) begin
            rnw_q    <= read_not_write_i;
            idx_q    <= req_idx;
            cnt_q    <= burst_size_i;
            be_q     <= byte_enables_i;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            bp_cnt_q <= '0;
            if (range_err) begin
              err_q   <= 1'b1;
              state_q <= StError;
            end else if (read_not_write_i) begin
              state_q <= StReadAddr;
            end else begin
              state_q <= StWrite;
            end
          end
        end
        StReadAddr: begin
          rdata_q  <= mem[idx_q];
          dvalid_q <= 1'b1;
          idx_q    <= idx_q + idx_t'(1);
          state_q  <= StReadBurst;
        end
        StReadBurst: begin
          // cnt_q counts beats still to fetch after the one now on the bus.
          if (cnt_q == 8'd0) begin
            end_q   <= 1'b1;
            state_q <= StReadEnd;
          end else begin
            rdata_q  <= mem[idx_q];
            dvalid_q <= 1'b1;
            idx_q    <= idx_q + idx_t'(1);
            cnt_q    <= cnt_q - 8'd1;
          end
        end
        StReadEnd: begin
          state_q <= StIdle;
        end
        StWrite: begin
          if (beat_acc) begin
            if (!full_q) begin
              idx_q <= idx_q + idx_t'(1);
              if (cnt_q == 8'd0) begin
                full_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q - 8'd1;
              end
            end else if (!ovf_q) begin
              ovf_q <= 1'b1;
              err_q <= 1'b1;
            end
            if (BusyPeriod != 0) begin
              if (bp_wrap) begin
                busy_q   <= 1'b1;
                bp_cnt_q <= '0;
              end else begin
                bp_cnt_q <= bp_cnt_q + 32'd1;
              end
            end
          end
          if (end_transaction_i) begin
            state_q <= StIdle;
          end
        end
        StError: begin
          // A rejected read is still closed by the slave; a write is closed by the master.
          if (rnw_q) begin
            end_q   <= 1'b1;
            state_q <= StReadEnd;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Bus outputs come straight from their registers.
  always_comb begin
    address_data_o    = rdata_q;
    data_valid_o      = dvalid_q;
    end_transaction_o = end_q;
    busy_o            = busy_q;
    bus_error_o       = err_q;
  end

endmodule

// File: doc/bus_sram_slave.md
# bus_sram_slave

Word-addressed on-chip SRAM that responds as a slave on the shared system bus. It is the target of the DMA custom-instruction block's burst reads and writes. It decodes single- and burst transactions within a configurable address window, returns read data one word per cycle, and absorbs write bursts with programmable back-pressure. Bus-range violations are signalled with the bus error protocol.

## Interface
- baseAddress, 32'h50000000, byte address of word 0; must be aligned to the window size.
- addressBits, 10, log2 of depth in 32-bit words; window size is 4<<addressBits bytes.
- busyPeriod, 0, if nonzero, busyOut asserts for one cycle after every busyPeriod accepted write beats; 0 disables back-pressure.

- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset) clear of all state.
- beginTransactionIn  in  1  master marks address/command cycle.
- endTransactionIn  in  1  master ends a write transaction.
- readNotWriteIn  in  1  1 = read, sampled with beginTransactionIn.
- dataValidIn  in  1  write beat valid on addressDataIn.
- addressDataIn  in  32  address on begin cycle, write data otherwise.
- byteEnablesIn  in  4  per-byte write enable, sampled on begin; applies to every beat.
- burstSizeIn  in  8  beats-1, sampled on begin (0 = single word, 255 = 256 words).
- addressDataOut  out  32  read data, 0 when dataValidOut is 0.
- dataValidOut  out  1  read beat valid.
- endTransactionOut  out  1  slave ends a read or error transaction.
- busyOut  out  1  write beat on addressDataIn is not accepted this cycle.
- busErrorOut  out  1  transaction rejected.

## Operation
- All outputs are registered. During reset: all outputs are 0, FSM is IDLE, and counters are 0. SRAM contents are not cleared.
- Hit: addressDataIn[31:addressBits+2] == baseAddress[31:addressBits+2] on the begin cycle. On a miss, the slave stays IDLE and drives nothing.
- Latched on begin: word index = addressDataIn[addressBits+1:2]; bits [1:0] are ignored. Also latched: beat counter = burstSizeIn, byte enables, and direction.
- Range check: if index + burstSizeIn > 2^addressBits - 1, the transaction is an error. There is no wrap-around inside the window.
- FSM states:
  - IDLE
  - READ_ADDR: one cycle; the synchronous RAM read is issued.
  - READ_BURST: one beat per cycle. Index increments, counter decrements, and the last beat is at counter == 0.
  - READ_END: endTransactionOut=1 for one cycle, then IDLE.
  - WRITE: accepts beats until endTransactionIn.
  - ERROR: busErrorOut=1 for one cycle, then IDLE.
- Read path:
  - IDLE -> READ_ADDR on a hit read, or -> ERROR on a range error.
  - READ_ADDR -> READ_BURST.
  - READ_BURST -> READ_END after the final beat.
  - READ_END -> IDLE.
- Write path:
  - IDLE -> WRITE on a hit write, or -> ERROR on a range error.
  - In WRITE, a beat is written when dataValidIn=1 and busyOut=0. The RAM word at index is written with byte enables; index increments.
  - A beat that arrives while busyOut=1 is not written. The master must hold it.
  - Beats beyond burstSizeIn+1 are discarded, and busErrorOut pulses once.
  - WRITE -> IDLE on the cycle endTransactionIn=1. A beat that is valid in the same cycle is still written if not busy.
- Back-pressure: an accepted-beat counter counts up. When it reaches busyPeriod, busyOut=1 on the next cycle and the counter clears.
- beginTransactionIn outside IDLE is ignored; the arbiter guarantees it does not occur.
- An asynchronous reset mid-burst aborts immediately. The master observes neither endTransactionOut nor busErrorOut.

## Timing
- Read latency: begin at cycle T gives the first dataValidOut at T+2.
  - Beat k is at T+2+k.
  - endTransactionOut is at T+3+burstSizeIn, with dataValidOut=0 on that cycle.
- Write: beats are accepted from T+1.
  - busyOut is the registered output and applies to the current cycle's beat.
  - Minimum write transaction is 2 cycles (begin, then beat with end).
- Error: busErrorOut is at T+1 for exactly one cycle. endTransactionOut is at T+2 for a read error. For a write error, the master ends the transaction.
- Back-to-back: a new begin is accepted the cycle after the slave returns to IDLE (T+4+burstSizeIn for reads).

## Test plan
- Single read: preload word 5 = 32'hDEADBEEF, begin read at 32'h50000014 with burstSizeIn=0 -> dataValidOut with 32'hDEADBEEF at T+2, endTransactionOut at T+3.
- Burst write then read: write 8 beats 1..8 to 32'h50000100 with burstSizeIn=7 and byteEnables=4'hF, then read back -> 8 consecutive beats 1..8, end at T+10.
- Byte enables: word 0 = 32'h11223344, write 32'hAABBCCDD with byteEnablesIn=4'b0101 -> read returns 32'h11BB33DD.
- Range error: read at the last word (index 1023) with burstSizeIn=1 -> busErrorOut at T+1, endTransactionOut at T+2, no dataValidOut. A miss at 32'h60000000 -> no output activity.
- Back-pressure: busyPeriod=3, write 6 beats held until accepted -> busyOut after beats 3 and 6, all 6 words correct, no duplicates.
- Reset mid-burst: drop reset during beat 3 of a 16-beat read -> all outputs 0 immediately; a subsequent read works normally.
